sar_adc_ctrl: RTL and testbench
===============================

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: conversion resolution in bits; must match averager Din width.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: clocks each trial code is held before the comparator decision; legal range 3..255.
REQ-003 SHALL have parameter PERIOD, default 40: clocks between conversion starts; must be >= WIDTH*SETTLE_CYCLES+1, checked at elaboration.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  continuous-conversion enable.
REQ-007 SHALL have port comp_in  input  1  asynchronous external comparator; 1 = Vin >= DAC output.
REQ-008 SHALL have port dac_code  output  WIDTH  trial code to the external DAC, registered.
REQ-009 SHALL have port Dout  output  WIDTH  last completed conversion result, registered; feeds averager Din.
REQ-010 SHALL have port Dout_valid  output  1  one-cycle strobe on a new Dout; feeds averager EN.
REQ-011 SHALL have port busy  output  1  high while a conversion is in progress (TRIAL or DONE).

Function
REQ-012 SHALL pass comp_in through a 2-flop synchronizer; only the synchronized value is used.
REQ-013 SHALL implement states IDLE, TRIAL, DONE.
REQ-014 SHALL run a period counter 0..PERIOD-1, wrapping, while en=1; held at 0 while en=0.
REQ-015 SHALL start a conversion (IDLE->TRIAL) on an edge where en=1, state=IDLE and period counter=0; on that edge result<=0, bit index<=WIDTH-1, dac_code<=1<<(WIDTH-1).
REQ-016 SHALL hold each trial code exactly SETTLE_CYCLES clocks; on the last clock, clear the current bit if synchronized comparator=0, else keep it.
REQ-017 SHALL, after a non-final bit decision, decrement the bit index and drive dac_code = kept bits | (1<<new index) on the same edge.
REQ-018 SHALL, after the bit-0 decision, go to DONE on that edge (edge start+WIDTH*SETTLE_CYCLES) with Dout<=final result, Dout_valid=1.
REQ-019 SHALL hold Dout_valid high for exactly one clock; SHALL leave DONE for IDLE on the next edge.
REQ-020 SHALL keep dac_code at the final result in DONE and IDLE until the next start.
REQ-021 SHALL, when en falls mid-conversion, complete the conversion and emit Dout_valid; no further start until en=1 and counter=0.
REQ-022 SHALL hold Dout unchanged between Dout_valid strobes.
REQ-023 SHALL ignore comp_in in IDLE and DONE.

Reset
REQ-024 SHALL, on reset_n=0 at any time incl. mid-conversion, immediately force state=IDLE, dac_code=0, Dout=0, Dout_valid=0, busy=0, period counter=0, synchronizer flops=0.
REQ-025 SHALL start the first conversion on the first rising edge with reset_n=1 and en=1.

Verification
REQ-026 SHALL cover: comparator model comp_in=(0x55>=dac_code), defaults -> dac_code 0x80,0x40,0x60,0x50,0x58,0x54,0x56,0x55, 4 clocks each; Dout=0x55, Dout_valid at edge 32 after start.
REQ-027 SHALL cover: Vin=0x00 and Vin=0xFF -> Dout=0x00 and 0xFF respectively (boundary codes).
REQ-028 SHALL cover: en held high 400 clocks, Vin=0xB7 -> Dout_valid every 40 clocks, 10 strobes, every Dout=0xB7, busy low 7 of every 40 clocks.
REQ-029 SHALL cover: en dropped 10 clocks after start -> that conversion still completes with one strobe, then IDLE; no further strobes.
REQ-030 SHALL cover: reset_n pulsed low at clock 15 of a conversion -> all outputs 0 within the same cycle, no strobe; restart on release with en=1.
REQ-031 SHALL cover: closed loop with averager (power=8), Vin=0x10 +/-4 LSB noise per conversion for 512 conversions -> averager Q[15:8] within 0x10 +/-1.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives trial codes to an external DAC,
// resolves one bit per SETTLE_CYCLES clocks and starts a conversion every PERIOD clocks.
module sar_adc_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned PERIOD        = 40
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] Dout,
    output logic             Dout_valid,
    output logic             busy
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned SET_W = 8;

    // Elaboration-time parameter legality
    if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("sar_adc_ctrl: SETTLE_CYCLES must be in 3..255");
    end
    if (PERIOD < WIDTH * SETTLE_CYCLES + 1) begin : g_bad_period
        $error("sar_adc_ctrl: PERIOD must be >= WIDTH*SETTLE_CYCLES+1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   dac_q, dac_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               sync1_q, sync2_q;

    logic               start_c;
    logic [WIDTH-1:0]   trial_bit_c;
    logic [WIDTH-1:0]   kept_c;

    assign dac_code   = dac_q;
    assign Dout       = dout_q;
    assign Dout_valid = valid_q;
    assign busy       = busy_q;

    // Comparator resynchronisation into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= comp_in;
            sync2_q <= sync1_q;
        end
    end

    // Free-running start timer, parked at zero while disabled
    always_comb begin
        per_cnt_d = per_cnt_q;
        if (!en) begin
            per_cnt_d = '0;
        end else if (per_cnt_q == CNT_W'(PERIOD - 1)) begin
            per_cnt_d = '0;
        end else begin
            per_cnt_d = per_cnt_q + CNT_W'(1);
        end
    end

    assign start_c     = en && (per_cnt_q == '0);
    assign trial_bit_c = WIDTH'(1) << idx_q;
    assign kept_c      = sync2_q ? dac_q : (dac_q & ~trial_bit_c);

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        set_cnt_d = set_cnt_q;
        idx_d     = idx_q;
        dac_d     = dac_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d   = TRIAL;
                    idx_d     = IDX_W'(WIDTH - 1);
                    dac_d     = WIDTH'(1) << (WIDTH - 1);
                    set_cnt_d = '0;
                end
            end
            TRIAL: begin
                if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    set_cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = DONE;
                        dac_d   = kept_c;
                        dout_d  = kept_c;
                        valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                        dac_d = kept_c | (WIDTH'(1) << (idx_q - IDX_W'(1)));
                    end
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            DONE: begin
                // A start landing on this edge (only when PERIOD is at its minimum) is not dropped
                if (start_c) begin
                    state_d   = TRIAL;
                    idx_d     = IDX_W'(WIDTH - 1);
                    dac_d     = WIDTH'(1) << (WIDTH - 1);
                    set_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            per_cnt_q <= '0;
            set_cnt_q <= '0;
            idx_q     <= '0;
            dac_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            set_cnt_q <= set_cnt_d;
            idx_q     <= idx_d;
            dac_q     <= dac_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl with an ideal comparator model and a result scoreboard.
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       comp_in;
    logic [7:0] vin;
    logic [7:0] dac_code;
    logic [7:0] Dout;
    logic       Dout_valid;
    logic       busy;

    int errors  = 0;
    int checks  = 0;
    int strobes = 0;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;

    sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(4), .PERIOD(40)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .comp_in    (comp_in),
        .dac_code   (dac_code),
        .Dout       (Dout),
        .Dout_valid (Dout_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Ideal comparator: 1 when Vin >= DAC output
    assign comp_in = (vin >= dac_code);

    // Scoreboard: every strobe must match the oldest expected result
    always @(negedge clk) begin
        if (reset_n && Dout_valid) begin
            strobes++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: strobe with Dout=%h but nothing expected", Dout);
            end else begin
                mon_exp = sb.pop_front();
                if (Dout !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_dout: got %h expected %h", Dout, mon_exp);
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: busy still %b after 100 cycles", name, busy);
        end
    endtask

    // Single conversion started by a one-clock en pulse
    task automatic run_one(input logic [7:0] v, input string name);
        @(negedge clk);
        vin = v;
        sb.push_back(v);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_idle(name);
        checks++;
        if (Dout !== v) begin
            errors++;
            $display("FAIL %s_dout: got %h expected %h", name, Dout, v);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en      = 1'b0;
        vin     = 8'h00;
        repeat (3) @(negedge clk);
        checks += 4;
        if (dac_code !== 8'h00) begin errors++; $display("FAIL rst_dac: got %h expected 00", dac_code); end
        if (Dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h expected 00", Dout); end
        if (Dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", Dout_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        // First rising edge with reset released and en high starts a conversion
        vin = 8'h3C;
        sb.push_back(8'h3C);
        en      = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL first_start_busy: got %b expected 1", busy); end
        if (dac_code !== 8'h80) begin errors++; $display("FAIL first_start_dac: got %h expected 80", dac_code); end
        en = 1'b0;
        wait_idle("first_conv");
    endtask

    task automatic test_trace();
        logic [7:0] res;
        logic [7:0] trial;
        @(negedge clk);
        vin = 8'h55;
        sb.push_back(8'h55);
        en = 1'b1;
        @(posedge clk);
        res = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            trial = res | (8'h01 << b);
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                checks++;
                if (dac_code !== trial) begin
                    errors++;
                    $display("FAIL trace_dac bit%0d clk%0d: got %h expected %h", b, j, dac_code, trial);
                end
            end
            if (vin >= trial) res = trial;
        end
        @(negedge clk);
        checks += 3;
        if (Dout_valid !== 1'b1) begin errors++; $display("FAIL trace_valid_edge32: got %b expected 1", Dout_valid); end
        if (Dout !== 8'h55) begin errors++; $display("FAIL trace_dout: got %h expected 55", Dout); end
        if (busy !== 1'b1) begin errors++; $display("FAIL trace_busy_done: got %b expected 1", busy); end
        @(negedge clk);
        en = 1'b0;
        checks += 3;
        if (Dout_valid !== 1'b0) begin errors++; $display("FAIL trace_valid_width: got %b expected 0", Dout_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL trace_busy_idle: got %b expected 0", busy); end
        if (dac_code !== 8'h55) begin errors++; $display("FAIL trace_dac_hold: got %h expected 55", dac_code); end
    endtask

    task automatic test_boundary();
        run_one(8'h00, "vin00");
        run_one(8'hFF, "vinFF");
    endtask

    task automatic test_continuous();
        int nstr;
        int busy_low;
        int last;
        int bad_gap;
        @(negedge clk);
        vin = 8'hB7;
        for (int k = 0; k < 10; k++) sb.push_back(8'hB7);
        nstr = 0; busy_low = 0; last = -1; bad_gap = 0;
        en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) busy_low++;
            if (Dout_valid) begin
                nstr++;
                if (last >= 0 && (i - last) != 40) bad_gap++;
                last = i;
            end
        end
        en = 1'b0;
        checks += 3;
        if (nstr != 10) begin errors++; $display("FAIL cont_strobes: got %0d expected 10", nstr); end
        if (busy_low != 70) begin errors++; $display("FAIL cont_busy_low: got %0d expected 70", busy_low); end
        if (bad_gap != 0) begin errors++; $display("FAIL cont_gap: %0d gaps not 40 clocks, expected 0", bad_gap); end
        repeat (50) @(negedge clk);
    endtask

    task automatic test_en_drop();
        int s0;
        @(negedge clk);
        vin = 8'h9A;
        sb.push_back(8'h9A);
        s0 = strobes;
        en = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (100) @(negedge clk);
        checks += 3;
        if (strobes - s0 != 1) begin errors++; $display("FAIL endrop_strobes: got %0d expected 1", strobes - s0); end
        if (busy !== 1'b0) begin errors++; $display("FAIL endrop_idle: busy %b expected 0", busy); end
        if (dac_code !== 8'h9A) begin errors++; $display("FAIL endrop_dac: got %h expected 9a", dac_code); end
    endtask

    task automatic test_reset_mid();
        int s0;
        @(negedge clk);
        vin = 8'h6E;
        s0 = strobes;
        en = 1'b1;
        repeat (15) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (dac_code !== 8'h00) begin errors++; $display("FAIL midrst_dac: got %h expected 00", dac_code); end
        if (Dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h expected 00", Dout); end
        if (Dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", Dout_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        repeat (3) @(negedge clk);
        sb.push_back(8'h6E);
        reset_n = 1'b1;
        @(negedge clk);
        checks += 3;
        if (strobes != s0) begin errors++; $display("FAIL midrst_nostrobe: got %0d strobes expected 0", strobes - s0); end
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_restart_busy: got %b expected 1", busy); end
        if (dac_code !== 8'h80) begin errors++; $display("FAIL midrst_restart_dac: got %h expected 80", dac_code); end
        en = 1'b0;
        wait_idle("midrst_conv");
        checks++;
        if (Dout !== 8'h6E) begin errors++; $display("FAIL midrst_dout: got %h expected 6e", Dout); end
    endtask

    task automatic test_average();
        int   sum;
        bit   got;
        int   avg;
        @(negedge clk);
        vin = 8'(16 + $urandom_range(0, 8) - 4);
        sb.push_back(vin);
        sum = 0;
        en = 1'b1;
        for (int n = 0; n < 512; n++) begin
            got = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (Dout_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL avg_timeout: no strobe for conversion %0d", n);
                break;
            end
            sum += int'(Dout);
            if (n == 511) begin
                en = 1'b0;
            end else begin
                vin = 8'(16 + $urandom_range(0, 8) - 4);
                sb.push_back(vin);
            end
        end
        en = 1'b0;
        avg = sum / 512;
        checks++;
        if (avg < 15 || avg > 17) begin
            errors++;
            $display("FAIL avg_mean: got %0d expected 16 +/-1", avg);
        end
        repeat (50) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_trace();
        test_boundary();
        test_continuous();
        test_en_drop();
        test_reset_mid();
        test_average();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d results never strobed, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
